// File: rtl/data_bus_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// data_bus_pkg : shared state type, default region map and sizing helpers
// Rev 1.0
// ----------------------------------------------------------------------------
package data_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } bus_state_t;

  localparam logic [31:0] DATA_REGION_BASE  = 32'h0000_0000;
  localparam logic [31:0] MMIO_REGION_BASE  = 32'h8000_0000;
  localparam logic [31:0] STACK_REGION_BASE = 32'hffff_0000;

  localparam logic [31:0] DATA_REGION_MASK  = 32'hfff0_0000;
  localparam logic [31:0] MMIO_REGION_MASK  = 32'hfff0_0000;
  localparam logic [31:0] STACK_REGION_MASK = 32'hffff_0000;

  // Low bit of slice idx inside a packed per-region vector.
  function automatic int region_lsb(input int idx, input int width);
    return idx * width;
  endfunction

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_width(input int t);
    return (t > 1) ? $clog2(t) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_bus_region_decoder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// data_bus_region_decoder : address to region hit vector, lowest index wins
// Rev 1.0
// ----------------------------------------------------------------------------
module data_bus_region_decoder
  import data_bus_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int NUM_REGIONS = 3,
  parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_BASE =
    {STACK_REGION_BASE, MMIO_REGION_BASE, DATA_REGION_BASE},
  parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_MASK =
    {STACK_REGION_MASK, MMIO_REGION_MASK, DATA_REGION_MASK},
  localparam int SEL_W = sel_width(NUM_REGIONS)
) (
  input  logic [ADDR_WIDTH-1:0]  address,
  output logic [NUM_REGIONS-1:0] hit,
  output logic [SEL_W-1:0]       hit_index,
  output logic                   any_hit
);

  for (genvar i = 0; i < NUM_REGIONS; i++) begin : g_hit
    assign hit[i] = (address & REGION_MASK[region_lsb(i, ADDR_WIDTH) +: ADDR_WIDTH])
                    == REGION_BASE[region_lsb(i, ADDR_WIDTH) +: ADDR_WIDTH];
  end

  assign any_hit = |hit;

  // Scan downwards so the lowest matching index is the last one written.
  always_comb begin
    hit_index = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        hit_index = SEL_W'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/data_memory_bus_router.sv
`default_nettype none
// ----------------------------------------------------------------------------
// data_memory_bus_router : routes core data requests to NUM_REGIONS targets
// Rev 1.0
// ----------------------------------------------------------------------------
module data_memory_bus_router
  import data_bus_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_REGIONS = 3,
  parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_BASE =
    {STACK_REGION_BASE, MMIO_REGION_BASE, DATA_REGION_BASE},
  parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_MASK =
    {STACK_REGION_MASK, MMIO_REGION_MASK, DATA_REGION_MASK},
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic [ADDR_WIDTH-1:0]             req_address,
  input  logic                              req_write,
  input  logic [DATA_WIDTH-1:0]             req_write_data,
  input  logic [DATA_WIDTH/8-1:0]           req_byte_enable,
  output logic                              resp_valid,
  output logic [DATA_WIDTH-1:0]             resp_read_data,
  output logic                              resp_error,
  output logic [NUM_REGIONS-1:0]            tgt_valid,
  output logic [ADDR_WIDTH-1:0]             tgt_address,
  output logic                              tgt_write,
  output logic [DATA_WIDTH-1:0]             tgt_write_data,
  output logic [DATA_WIDTH/8-1:0]           tgt_byte_enable,
  input  logic [NUM_REGIONS-1:0]            tgt_ready,
  input  logic [NUM_REGIONS*DATA_WIDTH-1:0] tgt_read_data
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int SEL_W    = sel_width(NUM_REGIONS);
  localparam int CNT_W    = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] c_cnt_last =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  bus_state_t            state_q, state_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [BE_WIDTH-1:0]   be_q, be_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic [NUM_REGIONS-1:0] w_hit;
  logic [SEL_W-1:0]       w_hit_index;
  logic                   w_any_hit;
  logic                   w_sel_ready;
  logic [DATA_WIDTH-1:0]  w_sel_rdata;

  data_bus_region_decoder #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .NUM_REGIONS (NUM_REGIONS),
    .REGION_BASE (REGION_BASE),
    .REGION_MASK (REGION_MASK)
  ) u_decoder (
    .address   (req_address),
    .hit       (w_hit),
    .hit_index (w_hit_index),
    .any_hit   (w_any_hit)
  );

  // Only the selected target's ready/data are ever looked at.
  always_comb begin
    w_sel_ready = 1'b0;
    w_sel_rdata = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (sel_q == SEL_W'(i)) begin
        w_sel_ready = tgt_ready[i];
        w_sel_rdata = tgt_read_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_address;
          write_d = req_write;
          wdata_d = req_write_data;
          be_d    = req_byte_enable;
          if (w_any_hit) begin
            sel_d   = w_hit_index;
            cnt_d   = '0;
            state_d = BUSY;
          end else begin
            rdata_d = '0;
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      BUSY: begin
        // Ready is checked first so a same-edge completion beats the timeout.
        if (w_sel_ready) begin
          rdata_d = write_q ? '0 : w_sel_rdata;
          err_d   = 1'b0;
          state_d = RESP;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == c_cnt_last)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    tgt_valid = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if ((state_q == BUSY) && (sel_q == SEL_W'(i))) begin
        tgt_valid[i] = 1'b1;
      end
    end
  end

  assign req_ready       = (state_q == IDLE);
  assign resp_valid      = (state_q == RESP);
  assign resp_read_data  = rdata_q;
  assign resp_error      = err_q;
  assign tgt_address     = addr_q;
  assign tgt_write       = write_q;
  assign tgt_write_data  = wdata_q;
  assign tgt_byte_enable = be_q;

endmodule
`default_nettype wire

// File: tb/tb_data_memory_bus_router.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_data_memory_bus_router : directed bench with a transaction-level model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_data_memory_bus_router;

  localparam int TMO = 64;

  logic        clock;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_address;
  logic        req_write;
  logic [31:0] req_write_data;
  logic [3:0]  req_byte_enable;
  logic        resp_valid;
  logic [31:0] resp_read_data;
  logic        resp_error;
  logic [2:0]  tgt_valid;
  logic [31:0] tgt_address;
  logic        tgt_write;
  logic [31:0] tgt_write_data;
  logic [3:0]  tgt_byte_enable;
  logic [2:0]  tgt_ready;
  logic [95:0] tgt_read_data;

  // Second instance: overlapping regions and a short timeout.
  logic        ov_req_valid;
  logic        ov_req_ready;
  logic [31:0] ov_req_address;
  logic        ov_resp_valid;
  logic [31:0] ov_resp_read_data;
  logic        ov_resp_error;
  logic [1:0]  ov_tgt_valid;
  logic [31:0] ov_tgt_address;
  logic        ov_tgt_write;
  logic [31:0] ov_tgt_write_data;
  logic [3:0]  ov_tgt_byte_enable;
  logic [1:0]  ov_tgt_ready;
  logic [63:0] ov_tgt_read_data;

  data_memory_bus_router dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_address(req_address),
    .req_write(req_write), .req_write_data(req_write_data), .req_byte_enable(req_byte_enable),
    .resp_valid(resp_valid), .resp_read_data(resp_read_data), .resp_error(resp_error),
    .tgt_valid(tgt_valid), .tgt_address(tgt_address), .tgt_write(tgt_write),
    .tgt_write_data(tgt_write_data), .tgt_byte_enable(tgt_byte_enable),
    .tgt_ready(tgt_ready), .tgt_read_data(tgt_read_data)
  );

  data_memory_bus_router #(
    .NUM_REGIONS(2),
    .REGION_BASE({32'h8000_0000, 32'h0000_0000}),
    .REGION_MASK({32'hfff0_0000, 32'h0000_0000}),
    .TIMEOUT_CYCLES(4)
  ) dut_ov (
    .clock(clock), .reset_n(reset_n),
    .req_valid(ov_req_valid), .req_ready(ov_req_ready), .req_address(ov_req_address),
    .req_write(1'b0), .req_write_data(32'h0), .req_byte_enable(4'hf),
    .resp_valid(ov_resp_valid), .resp_read_data(ov_resp_read_data), .resp_error(ov_resp_error),
    .tgt_valid(ov_tgt_valid), .tgt_address(ov_tgt_address), .tgt_write(ov_tgt_write),
    .tgt_write_data(ov_tgt_write_data), .tgt_byte_enable(ov_tgt_byte_enable),
    .tgt_ready(ov_tgt_ready), .tgt_read_data(ov_tgt_read_data)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit chk_en = 0;

  // Model of the current transaction, in cycle numbers of the bench counter.
  int          m_E, m_tv_lo, m_tv_hi, m_resp_cyc;
  logic [2:0]  m_oh;
  logic [31:0] m_addr, m_wdata, m_resp_data;
  logic        m_write, m_resp_err;
  logic [3:0]  m_be;
  logic [31:0] held_data;
  logic        held_err;
  int          cur_d;
  logic [2:0]  cur_noise;

  logic [2:0]  ob_tv;
  logic [3:0]  ob_be;
  logic [31:0] ob_wd;
  int          tv_cnt;

  logic [31:0] rg_base [3] = '{32'h0000_0000, 32'h8000_0000, 32'hffff_0000};
  logic [31:0] rg_mask [3] = '{32'hfff0_0000, 32'hfff0_0000, 32'hffff_0000};

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic int model_decode(input logic [31:0] a);
    for (int i = 0; i < 3; i++) begin
      if ((a & rg_mask[i]) == rg_base[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_idle();
    m_E = -10; m_tv_lo = -10; m_tv_hi = -11; m_resp_cyc = -10; m_oh = '0;
  endtask

  always @(posedge clock) begin
    #1;
    if (chk_en) begin
      logic       exp_ready, exp_rv;
      logic [2:0] exp_tv;
      exp_ready = !(cyc >= m_E && cyc <= m_resp_cyc);
      exp_tv    = (cyc >= m_tv_lo && cyc <= m_tv_hi) ? m_oh : 3'b000;
      exp_rv    = (cyc == m_resp_cyc);
      check("req_ready", req_ready, exp_ready);
      check("tgt_valid", tgt_valid, exp_tv);
      check("resp_valid", resp_valid, exp_rv);
      if (exp_rv) begin
        check("resp_read_data", resp_read_data, m_resp_data);
        check("resp_error", resp_error, m_resp_err);
        held_data = m_resp_data;
        held_err  = m_resp_err;
      end else begin
        check("held_read_data", resp_read_data, held_data);
        check("held_error", resp_error, held_err);
      end
      if (exp_tv != 3'b000) begin
        check("tgt_address", tgt_address, m_addr);
        check("tgt_write", tgt_write, m_write);
        check("tgt_write_data", tgt_write_data, m_wdata);
        check("tgt_byte_enable", tgt_byte_enable, m_be);
      end
    end
  end

  // d = cycles tgt_valid is high before the target raises ready; -1 = never.
  task automatic start_txn(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                           input logic [3:0] be, input int d, input logic [31:0] rd,
                           input logic [2:0] noise);
    int idx;
    @(negedge clock);
    req_valid = 1'b1; req_address = addr; req_write = wr;
    req_write_data = wd; req_byte_enable = be;
    m_E = cyc + 1; m_addr = addr; m_write = wr; m_wdata = wd; m_be = be;
    idx = model_decode(addr);
    m_tv_lo = m_E;
    if (idx < 0) begin
      m_oh = 3'b000; m_tv_hi = m_E - 1; m_resp_cyc = m_E;
      m_resp_data = '0; m_resp_err = 1'b1;
    end else if (d >= 0 && d <= TMO - 1) begin
      m_oh = 3'(1 << idx); m_tv_hi = m_E + d; m_resp_cyc = m_E + d + 1;
      m_resp_data = wr ? 32'h0 : rd; m_resp_err = 1'b0;
    end else begin
      m_oh = 3'(1 << idx); m_tv_hi = m_E + TMO - 1; m_resp_cyc = m_E + TMO;
      m_resp_data = '0; m_resp_err = 1'b1;
    end
    for (int i = 0; i < 3; i++) begin
      tgt_read_data[i*32 +: 32] = (i == idx) ? rd : (32'hbad0_0000 + 32'(i));
    end
    cur_d = d;
    cur_noise = noise & ~m_oh;
  endtask

  task automatic finish_txn();
    @(negedge clock);
    req_valid = 1'b0;
    ob_tv = tgt_valid; ob_be = tgt_byte_enable; ob_wd = tgt_write_data;
    tv_cnt = 0;
    for (int n = 0; n < 200; n++) begin
      if (tgt_valid != 3'b000) tv_cnt++;
      if (cyc >= m_resp_cyc) break;
      tgt_ready = cur_noise | ((cur_d >= 0 && cyc == m_E + cur_d) ? m_oh : 3'b000);
      @(negedge clock);
    end
    tgt_ready = '0;
  endtask

  task automatic run_txn(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                         input logic [3:0] be, input int d, input logic [31:0] rd,
                         input logic [2:0] noise);
    start_txn(addr, wr, wd, be, d, rd, noise);
    finish_txn();
  endtask

  initial begin
    int cnt;
    reset_n = 1'b1;
    req_valid = 0; req_address = '0; req_write = 0; req_write_data = '0; req_byte_enable = '0;
    tgt_ready = '0; tgt_read_data = '0;
    ov_req_valid = 0; ov_req_address = '0; ov_tgt_ready = '0; ov_tgt_read_data = '0;
    held_data = '0; held_err = 1'b0;
    model_idle();
    #1 reset_n = 1'b0;
    #2;
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_read_data", resp_read_data, 32'h0);
    check("rst_resp_error", resp_error, 1'b0);
    check("rst_tgt_valid", tgt_valid, 3'b000);
    check("rst_tgt_address", tgt_address, 32'h0);
    check("rst_tgt_write_data", tgt_write_data, 32'h0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    chk_en = 1'b1;
    repeat (2) @(negedge clock);

    // Read region 1 with a late target; region 0 waves ready meanwhile.
    run_txn(32'h8000_0010, 1'b0, 32'h0, 4'hf, 2, 32'hdead_beef, 3'b001);
    check("pin_t1_tgt_valid", ob_tv, 3'b010);
    check("pin_t1_tv_cycles", tv_cnt, 3);
    @(negedge clock);
    check("pin_t1_data", resp_read_data, 32'hdead_beef);
    check("pin_t1_err", resp_error, 1'b0);

    // Partial write to the stack region; target drives junk read data.
    run_txn(32'hffff_fffc, 1'b1, 32'h1234_5678, 4'b0011, 0, 32'hffff_ffff, 3'b000);
    check("pin_t2_tgt_valid", ob_tv, 3'b100);
    check("pin_t2_be", ob_be, 4'b0011);
    check("pin_t2_wdata", ob_wd, 32'h1234_5678);
    @(negedge clock);
    check("pin_t2_data", resp_read_data, 32'h0);

    // Unmapped address.
    run_txn(32'h4000_0000, 1'b0, 32'h0, 4'hf, 0, 32'h0, 3'b000);
    check("pin_t3_tgt_valid", ob_tv, 3'b000);
    @(negedge clock);
    check("pin_t3_err", resp_error, 1'b1);

    // Zero byte enables forwarded as-is.
    run_txn(32'h0000_0100, 1'b0, 32'h0, 4'b0000, 0, 32'h5a5a_0001, 3'b010);

    // Silent target: full timeout, then a normal request.
    run_txn(32'h8000_0004, 1'b0, 32'h0, 4'hf, -1, 32'h0, 3'b000);
    check("pin_t5_tv_cycles", tv_cnt, 64);
    run_txn(32'h0000_0200, 1'b0, 32'h0, 4'hf, 1, 32'h1111_2222, 3'b100);

    // Ready lands on the same edge the timeout would expire.
    run_txn(32'h8000_0020, 1'b0, 32'h0, 4'hf, TMO - 1, 32'hcafe_f00d, 3'b000);
    @(negedge clock);
    check("pin_t7_err", resp_error, 1'b0);
    check("pin_t7_data", resp_read_data, 32'hcafe_f00d);

    // Reset while BUSY.
    start_txn(32'h0000_0010, 1'b0, 32'h0, 4'hf, -1, 32'h0, 3'b000);
    @(negedge clock);
    req_valid = 1'b0;
    repeat (3) @(negedge clock);
    #2;
    chk_en = 1'b0;
    reset_n = 1'b0;
    #1;
    check("arst_tgt_valid", tgt_valid, 3'b000);
    check("arst_resp_valid", resp_valid, 1'b0);
    model_idle();
    held_data = '0; held_err = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    chk_en = 1'b1;
    repeat (6) @(negedge clock);
    run_txn(32'hffff_0000, 1'b0, 32'h0, 4'hf, 0, 32'h7777_8888, 3'b000);

    // Overlapping regions: region 0 matches everything and must win.
    @(negedge clock);
    ov_req_valid = 1'b1; ov_req_address = 32'h8000_0010;
    ov_tgt_ready = 2'b10; ov_tgt_read_data = {32'hbad0_bad0, 32'h0123_4567};
    @(negedge clock);
    ov_req_valid = 1'b0;
    check("ov_sel", ov_tgt_valid, 2'b01);
    check("ov_ignore_r1", ov_resp_valid, 1'b0);
    @(negedge clock);
    check("ov_ignore_r1_b", ov_resp_valid, 1'b0);
    ov_tgt_ready = 2'b11;
    @(negedge clock);
    ov_tgt_ready = 2'b00;
    check("ov_resp_valid", ov_resp_valid, 1'b1);
    check("ov_data", ov_resp_read_data, 32'h0123_4567);
    check("ov_err", ov_resp_error, 1'b0);
    check("ov_tgt_drop", ov_tgt_valid, 2'b00);

    // Short timeout on the second instance.
    @(negedge clock);
    @(negedge clock);
    ov_req_valid = 1'b1; ov_req_address = 32'h0000_1234;
    @(negedge clock);
    ov_req_valid = 1'b0;
    cnt = 0;
    for (int n = 0; n < 20; n++) begin
      if (ov_resp_valid) break;
      if (ov_tgt_valid != 2'b00) cnt++;
      @(negedge clock);
    end
    check("ov_tmo_resp", ov_resp_valid, 1'b1);
    check("ov_tmo_cycles", cnt, 4);
    check("ov_tmo_err", ov_resp_error, 1'b1);
    check("ov_tmo_data", ov_resp_read_data, 32'h0);

    repeat (4) @(negedge clock);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
